// File: rtl/data_mem_responder.sv
// Purpose: memory-stage data bus responder. RAM-region accesses go to a
//          byte-lane word RAM, and MMIO-window accesses run a req/ack
//          transaction on the peripheral port.
// Latency: RAM loads return on mem_dout one cycle after the request. MMIO
//          accesses take at least 3 cycles (IDLE->WAIT->DONE).
// Backpressure: mem_hold freezes the pipeline while an MMIO access is
//          outstanding. It is raised combinationally in the request cycle.
//
// Ports:
//   clk, Rst                      clock, synchronous active-high reset
//   mem_wea/mem_rea               store/load request
//   mem_en[3:0]                   byte-lane enables (already position-encoded)
//   mem_addr[31:0]/mem_din[31:0]  byte address / LSB-aligned store data
//   mem_dout[31:0]                LSB-aligned load data (registered)
//   mem_hold                      pipeline stall
//   mmio_req/we/addr/wdata/be     peripheral request and captured fields
//   mmio_rdata/mmio_ack           peripheral read data / single-cycle completion
//   mmio_err                      sticky timeout flag
module data_mem_responder #(
  parameter int          ADDR_BITS    = 12,
  parameter logic [31:0] MMIO_BASE    = 32'hAAAAA000,
  parameter logic [31:0] MMIO_MASK    = 32'hFFFFF000,
  parameter int          MMIO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_hold,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [11:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_be,
  input  logic [31:0] mmio_rdata,
  input  logic        mmio_ack,
  output logic        mmio_err
);

  localparam int DEPTH = 1 << (ADDR_BITS - 2);
  localparam int CNT_W = (MMIO_TIMEOUT < 1) ? 1 : $clog2(MMIO_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  // Rotate left by 8*sh: places LSB-aligned store data on its byte lanes.
  function automatic logic [31:0] rotl(input logic [31:0] d, input logic [1:0] sh);
    logic [31:0] r;
    case (sh)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[7:0],  d[31:8]};
    endcase
    return r;
  endfunction

  // Rotate right by 8*sh: brings the addressed byte down to bit 0.
  function automatic logic [31:0] rotr(input logic [31:0] d, input logic [1:0] sh);
    logic [31:0] r;
    case (sh)
      2'd0:    r = d;
      2'd1:    r = {d[7:0],  d[31:8]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[23:0], d[31:24]};
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        dout_q, dout_d;
  logic [31:0]        lat_q, lat_d;
  logic               we_q, we_d;
  logic               rd_q, rd_d;
  logic [11:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               err_q, err_d;
  logic               hold;
  logic [3:0]         ram_we;

  logic [31:0]          ram_q [DEPTH];
  logic [ADDR_BITS-3:0] ram_idx;
  logic [31:0]          ram_rd;
  logic [31:0]          ram_wdata;
  logic                 mmio_hit;
  logic                 access;

  // Upper address bits beyond ADDR_BITS are ignored, so RAM aliases.
  assign ram_idx   = mem_addr[ADDR_BITS-1:2];
  assign ram_rd    = ram_q[ram_idx];
  assign ram_wdata = rotl(mem_din, mem_addr[1:0]);
  assign mmio_hit  = (mem_addr & MMIO_MASK) == MMIO_BASE;
  assign access    = mem_rea | mem_wea;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    lat_d   = lat_q;
    we_d    = we_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    err_d   = err_q;
    hold    = 1'b0;
    ram_we  = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (access && mmio_hit) begin
          hold    = 1'b1;
          state_d = S_WAIT;
          cnt_d   = '0;
          we_d    = mem_wea;
          rd_d    = mem_rea;
          addr_d  = mem_addr[11:0];
          wdata_d = mem_din;
          be_d    = mem_en;
        end else begin
          ram_we = {4{mem_wea}} & mem_en;
          // The read uses the pre-write word, which gives read-first semantics.
          if (mem_rea) dout_d = rotr(ram_rd, mem_addr[1:0]);
        end
      end
      S_WAIT: begin
        hold  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // Ack is tested first so that it wins over a coincident timeout.
        if (mmio_ack) begin
          lat_d   = rotr(mmio_rdata, addr_q[1:0]);
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(MMIO_TIMEOUT)) begin
          lat_d   = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // The bus request is still presented here, so it is ignored to avoid
        // re-triggering the access.
        if (rd_q) dout_d = lat_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= 32'h0;
      lat_q   <= 32'h0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 12'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      lat_q   <= lat_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  // The RAM has no reset, so its contents survive Rst. Writes are blocked
  // during reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!Rst && ram_we[k]) ram_q[ram_idx][8*k +: 8] <= ram_wdata[8*k +: 8];
    end
  end

  assign mem_dout   = dout_q;
  assign mem_hold   = hold;
  assign mmio_req   = (state_q == S_WAIT);
  assign mmio_we    = we_q;
  assign mmio_addr  = addr_q;
  assign mmio_wdata = wdata_q;
  assign mmio_be    = be_q;
  assign mmio_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: directed self-checking bench for data_mem_responder.
// Latency: checks are sampled 2 time units after each rising edge.
// Backpressure: mem_hold is checked against hand-computed cycle positions.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        Rst;
  logic        mem_wea, mem_rea;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_hold, mmio_req, mmio_we;
  logic [11:0] mmio_addr;
  logic [31:0] mmio_wdata, mmio_rdata;
  logic [3:0]  mmio_be;
  logic        mmio_ack, mmio_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_responder dut (
    .clk(clk), .Rst(Rst),
    .mem_wea(mem_wea), .mem_rea(mem_rea), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_hold(mem_hold), .mmio_req(mmio_req), .mmio_we(mmio_we),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_be(mmio_be),
    .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack), .mmio_err(mmio_err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic re, input logic [3:0] en,
                     input logic [31:0] a, input logic [31:0] d);
    mem_wea  = we;
    mem_rea  = re;
    mem_en   = en;
    mem_addr = a;
    mem_din  = d;
  endtask

  initial begin
    Rst = 1'b1; mmio_ack = 1'b0; mmio_rdata = 32'h0;
    bus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick(); tick();
    Rst = 1'b0;
    check("rst_dout", mem_dout, 32'h0);
    check("rst_hold", {31'h0, mem_hold}, 32'h0);
    check("rst_req",  {31'h0, mmio_req}, 32'h0);
    check("rst_we",   {31'h0, mmio_we},  32'h0);
    check("rst_addr", {20'h0, mmio_addr}, 32'h0);
    check("rst_err",  {31'h0, mmio_err}, 32'h0);

    // RAM word store/load
    bus(1'b1, 1'b0, 4'b1111, 32'h10, 32'h11223344);
    #1 check("sw_hold", {31'h0, mem_hold}, 32'h0);
    tick();
    bus(1'b0, 1'b1, 4'b0000, 32'h10, 32'h0);
    tick();
    check("lw_10", mem_dout, 32'h11223344);

    // byte store at lane 1
    bus(1'b1, 1'b0, 4'b0010, 32'h11, 32'h000000AB);
    tick();
    bus(1'b0, 1'b1, 4'b0000, 32'h10, 32'h0);
    tick();
    check("sb_lw10", mem_dout, 32'h1122AB44);
    bus(1'b0, 1'b1, 4'b0000, 32'h11, 32'h0);
    tick();
    check("lw_11_rot", mem_dout, 32'h441122AB);

    // read and write together: old data returned
    bus(1'b1, 1'b1, 4'b1111, 32'h10, 32'h11223344);
    tick();
    check("read_first", mem_dout, 32'h1122AB44);
    bus(1'b0, 1'b0, 4'b0000, 32'h10, 32'h0);
    tick();
    check("idle_hold_dout", mem_dout, 32'h1122AB44);

    // halfword wrapping lanes 3 and 0
    bus(1'b1, 1'b0, 4'b1001, 32'h13, 32'h0000BEEF);
    tick();
    bus(1'b0, 1'b1, 4'b0000, 32'h10, 32'h0);
    tick();
    check("sh_word", mem_dout, 32'hEF2233BE);
    bus(1'b0, 1'b1, 4'b0000, 32'h13, 32'h0);
    tick();
    check("lw_13_rot", mem_dout, 32'h2233BEEF);
    bus(1'b0, 1'b1, 4'b0000, 32'h1010, 32'h0);
    tick();
    check("alias", mem_dout, 32'hEF2233BE);

    // MMIO read, ack on 3rd WAIT cycle
    bus(1'b0, 1'b1, 4'b1111, 32'hAAAAA008, 32'h0);
    #1 check("mr_hold_idle", {31'h0, mem_hold}, 32'h1);
    check("mr_req_idle", {31'h0, mmio_req}, 32'h0);
    tick();
    check("mr_w1_req",  {31'h0, mmio_req}, 32'h1);
    check("mr_w1_hold", {31'h0, mem_hold}, 32'h1);
    check("mr_we",      {31'h0, mmio_we},  32'h0);
    check("mr_addr",    {20'h0, mmio_addr}, 32'h008);
    check("mr_dout_held", mem_dout, 32'hEF2233BE);
    tick();
    check("mr_w2_hold", {31'h0, mem_hold}, 32'h1);
    tick();
    check("mr_w3_req", {31'h0, mmio_req}, 32'h1);
    mmio_ack = 1'b1; mmio_rdata = 32'h0000005A;
    tick();
    mmio_ack = 1'b0; mmio_rdata = 32'hDEADBEEF;
    check("mr_done_hold", {31'h0, mem_hold}, 32'h0);
    check("mr_done_req",  {31'h0, mmio_req}, 32'h0);
    check("mr_done_dout", mem_dout, 32'hEF2233BE);
    tick();
    bus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    check("mr_dout", mem_dout, 32'h0000005A);
    check("mr_no_retrig", {31'h0, mmio_req}, 32'h0);
    tick();
    check("mr_still_idle", {31'h0, mmio_req}, 32'h0);

    // MMIO write with no ack: timeout after 16 WAIT cycles
    bus(1'b1, 1'b0, 4'b1111, 32'hAAAAA004, 32'h0000CAFE);
    tick();
    check("mw_we",    {31'h0, mmio_we}, 32'h1);
    check("mw_addr",  {20'h0, mmio_addr}, 32'h004);
    check("mw_wdata", mmio_wdata, 32'h0000CAFE);
    check("mw_be",    {28'h0, mmio_be}, 32'hF);
    for (int i = 0; i < 15; i++) tick();
    check("mw_w16_req", {31'h0, mmio_req}, 32'h1);
    check("mw_w16_err", {31'h0, mmio_err}, 32'h0);
    tick();
    check("mw_to_err",  {31'h0, mmio_err}, 32'h1);
    check("mw_to_req",  {31'h0, mmio_req}, 32'h0);
    check("mw_to_hold", {31'h0, mem_hold}, 32'h0);
    tick();
    bus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    check("mw_dout_same", mem_dout, 32'h0000005A);
    mmio_ack = 1'b1; mmio_rdata = 32'h12345678;
    tick();
    mmio_ack = 1'b0;
    check("ack_idle_ignored", mem_dout, 32'h0000005A);
    check("ack_idle_req", {31'h0, mmio_req}, 32'h0);
    check("err_sticky", {31'h0, mmio_err}, 32'h1);

    // reset during WAIT
    bus(1'b0, 1'b1, 4'b1111, 32'hAAAAA000, 32'h0);
    tick();
    check("rw_req", {31'h0, mmio_req}, 32'h1);
    Rst = 1'b1;
    bus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    tick();
    Rst = 1'b0;
    check("rw_req0",  {31'h0, mmio_req}, 32'h0);
    check("rw_hold0", {31'h0, mem_hold}, 32'h0);
    check("rw_dout0", mem_dout, 32'h0);
    check("rw_err0",  {31'h0, mmio_err}, 32'h0);
    bus(1'b0, 1'b1, 4'b0000, 32'h10, 32'h0);
    tick();
    check("ram_kept", mem_dout, 32'hEF2233BE);

    // ack coincides with timeout: ack wins, data rotated by addr[1:0]=2
    bus(1'b0, 1'b1, 4'b1111, 32'hAAAAA002, 32'h0);
    tick();
    check("co_addr", {20'h0, mmio_addr}, 32'h002);
    for (int i = 0; i < 15; i++) tick();
    mmio_ack = 1'b1; mmio_rdata = 32'h11223344;
    tick();
    mmio_ack = 1'b0;
    check("co_err", {31'h0, mmio_err}, 32'h0);
    tick();
    bus(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    check("co_dout", mem_dout, 32'h33441122);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
